// File: rtl/sha3_feeder_pkg.sv
// Shared types and constants for the SHA3 Avalon-MM feeder.
// Holds the FSM state enum, the control-word bit layout, default slave
// word offsets, and a helper that assembles a control-register write.
package sha3_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_DATA,
        ST_FINAL,
        ST_RD,
        ST_OUT
    } state_t;

    localparam int unsigned INIT_BIT  = 3;
    localparam int unsigned BYTES_LSB = 1;
    localparam int unsigned FINAL_BIT = 0;

    localparam logic [7:0]  DEF_ADDR_DATA    = 8'h00;
    localparam logic [7:0]  DEF_ADDR_CTRL    = 8'h01;
    localparam logic [7:0]  DEF_ADDR_DIGEST  = 8'h10;
    localparam int unsigned DEF_DIGEST_WORDS = 8;

    // Control word: init, valid bytes of the last word, finalize; all else zero.
    function automatic logic [31:0] ctrl_word(input logic init, input logic [1:0] bytes,
                                              input logic fin);
        logic [31:0] w;
        w                 = '0;
        w[INIT_BIT]       = init;
        w[BYTES_LSB +: 2] = bytes;
        w[FINAL_BIT]      = fin;
        return w;
    endfunction

endpackage

// File: rtl/avmm_master_port.sv
// Avalon-MM master request registers.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   issue, issue_read,          load a new request at the next edge; caller only
//   issue_addr, issue_wdata     issues when the port is free or completing
//   done_c                      current request completes at this edge
//   rd_data                     readdata captured from the last completed read
//   avm_*                       Avalon-MM master signals
module avmm_master_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue,
    input  logic        issue_read,
    input  logic [7:0]  issue_addr,
    input  logic [31:0] issue_wdata,
    output logic        done_c,
    output logic [31:0] rd_data,
    output logic [7:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    assign done_c = (avm_read || avm_write) && !avm_waitrequest;

    // Request registers only move when idle or on completion, so they hold under waitrequest.
    always_ff @(posedge clk) begin
        if (reset) begin
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            rd_data       <= '0;
        end else begin
            if (done_c && avm_read) begin
                rd_data <= avm_readdata;
            end
            if (issue) begin
                avm_read    <= issue_read;
                avm_write   <= !issue_read;
                avm_address <= issue_addr;
                if (!issue_read) begin
                    avm_writedata <= issue_wdata;
                end
            end else if (done_c) begin
                avm_read  <= 1'b0;
                avm_write <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sha3_avmm_feeder.sv
// Feeds a message stream into the SHA3 Avalon slave and streams the digest back.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last/in_bytes   message word stream
//   avm_*                               Avalon-MM master to the SHA3 slave
//   out_valid/out_ready/out_data/out_last        digest word stream
//   busy                                high whenever the FSM is not idle
module sha3_avmm_feeder
    import sha3_feeder_pkg::*;
#(
    parameter logic [7:0]  ADDR_DATA    = DEF_ADDR_DATA,
    parameter logic [7:0]  ADDR_CTRL    = DEF_ADDR_CTRL,
    parameter logic [7:0]  ADDR_DIGEST  = DEF_ADDR_DIGEST,
    parameter int unsigned DIGEST_WORDS = DEF_DIGEST_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic [7:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy
);

    localparam int unsigned   IDX_W    = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGEST_WORDS - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              last_q;
    logic [1:0]        bytes_q;

    logic              done_c;
    logic              accept_c;
    logic              issue_c;
    logic              issue_read_c;
    logic [7:0]        issue_addr_c;
    logic [31:0]       issue_wdata_c;

    // Stop taking words once the last one is in; otherwise accept when the bus slot frees.
    assign in_ready = (state == ST_DATA) && !last_q && (!avm_write || !avm_waitrequest);
    assign accept_c = in_valid && in_ready;

    // Next bus request, issued on the same edge as the state change that needs it.
    always_comb begin
        issue_c       = 1'b0;
        issue_read_c  = 1'b0;
        issue_addr_c  = ADDR_CTRL;
        issue_wdata_c = '0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    issue_c       = 1'b1;
                    issue_wdata_c = ctrl_word(1'b1, 2'b00, 1'b0);
                end
            end
            ST_DATA: begin
                if (accept_c) begin
                    issue_c       = 1'b1;
                    issue_addr_c  = ADDR_DATA;
                    issue_wdata_c = in_data;
                end else if (done_c && last_q) begin
                    issue_c       = 1'b1;
                    issue_wdata_c = ctrl_word(1'b0, bytes_q, 1'b1);
                end
            end
            ST_FINAL: begin
                if (done_c) begin
                    issue_c      = 1'b1;
                    issue_read_c = 1'b1;
                    issue_addr_c = ADDR_DIGEST;
                end
            end
            ST_OUT: begin
                if (out_ready && idx != IDX_LAST) begin
                    issue_c      = 1'b1;
                    issue_read_c = 1'b1;
                    issue_addr_c = ADDR_DIGEST + 8'(idx) + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Sequencing FSM with registered stream-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            last_q    <= 1'b0;
            bytes_q   <= 2'b00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state  <= ST_INIT;
                        busy   <= 1'b1;
                        last_q <= 1'b0;
                        idx    <= '0;
                    end
                end
                ST_INIT: begin
                    if (done_c) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept_c) begin
                        last_q  <= in_last;
                        bytes_q <= in_last ? in_bytes : 2'b00;
                    end else if (done_c && last_q) begin
                        state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    if (done_c) begin
                        idx   <= '0;
                        state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (done_c) begin
                        state     <= ST_OUT;
                        out_valid <= 1'b1;
                        out_last  <= (idx == IDX_LAST);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (idx == IDX_LAST) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            idx   <= IDX_W'(idx + 1'b1);
                            state <= ST_RD;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    avmm_master_port u_port (
        .clk             (clk),
        .reset           (reset),
        .issue           (issue_c),
        .issue_read      (issue_read_c),
        .issue_addr      (issue_addr_c),
        .issue_wdata     (issue_wdata_c),
        .done_c          (done_c),
        .rd_data         (out_data),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

endmodule

// File: tb/tb_sha3_avmm_feeder.sv
// Self-checking bench for sha3_avmm_feeder: a per-message transaction model
// (expected bus writes/reads, digest words, and zero-stall cycle timing)
// driven from a vector table plus randomized messages and a mid-read reset.
module tb_sha3_avmm_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [1:0]  in_bytes = 2'b00;
    logic [7:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    always #5 clk = ~clk;

    sha3_avmm_feeder dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_last         (in_last),
        .in_bytes        (in_bytes),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .busy            (busy)
    );

    typedef struct {
        int          nwords;
        logic [1:0]  bytes;
        logic [31:0] w0;          // forced first word, 0 = random
        int          stall_pct;
        int          ostall_pct;
        int          gap_pct;
        int          data_stall;  // forced waitrequest cycles on data writes
        int          rd0_stall;   // forced waitrequest cycles on digest read 0
        bit          dead;        // digest word 0 reads as DEADBEEF
        int          hold_word;   // digest index held with out_ready=0 for 10 cycles
        logic [31:0] exp_final;
        bit          timed;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [15:0] salt = 16'h0;
    bit          dead = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [7:0] a);
        return (dead && a == 8'h10) ? 32'hDEADBEEF : {salt, 8'hC3, a};
    endfunction

    task automatic run_message(input vec_t v, input int abort_rd);
        logic [31:0] words[$];
        logic [40:0] exp_bus[$];
        logic [40:0] act_bus[$];
        logic [32:0] exp_out[$];
        logic [32:0] act_out[$];
        int          bus_cyc[$];
        int          fire_cyc[$];
        int          out_cyc[$];
        int          ptr = 0, nout = 0, cyc = 0, dstall = 0, rstall = 0, hold = 0;
        bit          pres = 0, done = 0, started = 0, aborted = 0;
        logic        p_req = 0, p_wait = 0, p_ov = 0, p_or = 0;
        logic [41:0] p_bus = '0;
        logic [31:0] p_od = '0;
        logic [40:0] e;
        logic [32:0] o;
        int          k;

        k    = v.nwords;
        salt = 16'($urandom);
        dead = v.dead;
        for (int i = 0; i < k; i++)
            words.push_back((i == 0 && v.w0 != 0) ? v.w0 : $urandom);

        exp_bus.push_back({1'b1, 8'h01, 32'h8});
        for (int i = 0; i < k; i++) exp_bus.push_back({1'b1, 8'h00, words[i]});
        exp_bus.push_back({1'b1, 8'h01, {29'b0, v.bytes, 1'b1}});
        for (int i = 0; i < 8; i++) begin
            exp_bus.push_back({1'b0, 8'(8'h10 + i), rd_fn(8'(8'h10 + i))});
            exp_out.push_back({(i == 7), rd_fn(8'(8'h10 + i))});
        end

        while (!done && cyc < 3000) begin
            @(negedge clk);
            if (abort_rd >= 0 && avm_read && avm_address == 8'(8'h10 + abort_rd)) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                check("abort_read", avm_read, 0);
                check("abort_write", avm_write, 0);
                check("abort_idle", busy, 0);
                check("abort_outv", out_valid, 0);
                @(negedge clk);
                reset    = 1'b0;
                in_valid = 1'b0;
                aborted  = 1;
                break;
            end
            if (avm_write && avm_address == 8'h00 && dstall < v.data_stall) begin
                avm_waitrequest = 1'b1;
                dstall++;
            end else if (avm_read && avm_address == 8'h10 && rstall < v.rd0_stall) begin
                avm_waitrequest = 1'b1;
                rstall++;
            end else begin
                avm_waitrequest = ($urandom_range(0, 99) < v.stall_pct);
            end
            avm_readdata = rd_fn(avm_address);
            if (!pres && ptr < k && $urandom_range(0, 99) >= v.gap_pct) pres = 1;
            in_valid = pres;
            in_data  = pres ? words[ptr] : 32'h0;
            in_last  = pres && (ptr == k - 1);
            in_bytes = in_last ? v.bytes : 2'($urandom);
            if (out_valid && nout == v.hold_word && hold < 10) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = ($urandom_range(0, 99) >= v.ostall_pct);
            end
            #1;
            if (p_req && p_wait)
                check("bus_hold", {avm_address, avm_read, avm_write, avm_writedata}, p_bus);
            if (avm_read || avm_write) check("rw_excl", avm_read & avm_write, 0);
            if (avm_write && avm_waitrequest) check("in_ready_stall", in_ready, 0);
            if (p_ov && !p_or) check("out_hold", {out_valid, out_data}, {1'b1, p_od});
            if (out_valid) check("no_read_in_out", avm_read, 0);
            if (started) check("busy", busy, 1);
            else check("idle_in_ready", in_ready, 0);

            if ((avm_read || avm_write) && !avm_waitrequest) begin
                act_bus.push_back({avm_write, avm_address, avm_write ? avm_writedata : avm_readdata});
                bus_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                fire_cyc.push_back(cyc);
                ptr++;
                pres = 0;
            end
            if (out_valid && out_ready) begin
                act_out.push_back({out_last, out_data});
                out_cyc.push_back(cyc);
                nout++;
                if (out_last || nout >= 8) done = 1;
            end
            p_req  = avm_read || avm_write;
            p_wait = avm_waitrequest;
            p_bus  = {avm_address, avm_read, avm_write, avm_writedata};
            p_ov   = out_valid;
            p_or   = out_ready;
            p_od   = out_data;
            if (in_valid) started = 1;
            cyc++;
        end
        if (aborted) return;

        check("timeout", done, 1);
        check("bus_count", act_bus.size(), exp_bus.size());
        for (int i = 0; i < exp_bus.size() && i < act_bus.size(); i++)
            check($sformatf("bus%0d", i), act_bus[i], exp_bus[i]);
        check("out_count", act_out.size(), 8);
        for (int i = 0; i < 8 && i < act_out.size(); i++)
            check($sformatf("out%0d", i), act_out[i], exp_out[i]);
        if (act_bus.size() > k + 1) begin
            e = act_bus[k + 1];
            check("final_ctrl", e[31:0], v.exp_final);
        end
        if (v.dead && act_out.size() > 0) begin
            o = act_out[0];
            check("deadbeef", o[31:0], 32'hDEADBEEF);
        end
        if (v.data_stall > 0) check("data_stall_len", dstall, v.data_stall);
        if (v.rd0_stall > 0) check("rd0_stall_len", rstall, v.rd0_stall);
        if (v.hold_word >= 0) check("out_hold_len", hold, 10);
        if (v.timed) begin
            for (int i = 0; i < bus_cyc.size(); i++)
                check($sformatf("bus_cyc%0d", i), bus_cyc[i],
                      (i == 0) ? 1 : (i <= k) ? 2 + i : (i == k + 1) ? 3 + k
                                   : 4 + k + 2 * (i - k - 2));
            for (int i = 0; i < fire_cyc.size(); i++)
                check($sformatf("in_cyc%0d", i), fire_cyc[i], 2 + i);
            for (int i = 0; i < out_cyc.size(); i++)
                check($sformatf("out_cyc%0d", i), out_cyc[i], 5 + k + 2 * i);
        end

        @(negedge clk);
        in_valid        = 1'b0;
        out_ready       = 1'b0;
        avm_waitrequest = 1'b0;
        #1;
        check("end_busy", busy, 0);
        check("end_outv", out_valid, 0);
        if (!done) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        tbl[0] = '{1, 2'd1, 32'h61, 0, 0, 0, 0, 0, 0, -1, 32'h3, 1};
        tbl[1] = '{5, 2'd2, 32'h0, 0, 0, 0, 0, 0, 0, -1, 32'h5, 1};
        tbl[2] = '{1, 2'd3, 32'h0, 0, 0, 0, 7, 20, 1, -1, 32'h7, 0};
        tbl[3] = '{3, 2'd0, 32'h0, 0, 0, 0, 0, 0, 0, 3, 32'h1, 0};
        tbl[4] = '{4, 2'd1, 32'h0, 30, 30, 30, 0, 0, 0, -1, 32'h3, 0};
        tbl[5] = '{2, 2'd0, 32'h0, 50, 20, 50, 0, 0, 0, -1, 32'h1, 0};

        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_read", avm_read, 0);
        check("rst_write", avm_write, 0);
        check("rst_addr", avm_address, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_outv", out_valid, 0);
        check("rst_odata", out_data, 0);
        check("rst_olast", out_last, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 6; r++) run_message(tbl[r], -1);

        for (int r = 0; r < 6; r++) begin
            rv           = tbl[4];
            rv.nwords    = $urandom_range(1, 7);
            rv.bytes     = 2'($urandom);
            rv.stall_pct = $urandom_range(0, 60);
            rv.ostall_pct = $urandom_range(0, 60);
            rv.gap_pct   = $urandom_range(0, 60);
            rv.exp_final = {29'b0, rv.bytes, 1'b1};
            run_message(rv, -1);
        end

        run_message(tbl[3], 2);
        run_message(tbl[0], -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
